wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  MEM/WB pipeline register and writeback mux. Directly feeds regFile.
//  - Captures one instruction per cycle from MEM.
//  - Selects ALU result, load data or link address as writeData.
//  - Drives regWrite, Jreg, writeReg and writeData into regFile.
//  - Keeps a count of retired instructions.
// PARAMETERS
//  DATA_W  32  datapath width; only 32 is supported
//  REG_AW  5   register index width (32 registers)
// PORTS
//  clk             in   1       rising-edge clock shared with regFile
//  rst_n           in   1       asynchronous active-low reset
//  in_valid        in   1       MEM stage holds a real instruction
//  stall           in   1       hold stage contents this cycle
//  flush           in   1       capture a bubble instead of MEM contents
//  mem_reg_write   in   1       instruction writes a register
//  mem_jreg        in   1       jr-class instruction; regFile suppresses write
//  mem_wb_sel      in   2       00 ALU, 01 load, 10 link (PC+4), 11 = ALU
//  mem_dest        in   REG_AW  destination register index
//  mem_alu_result  in   DATA_W  ALU result; [1:0] is the load byte address
//  mem_load_data   in   DATA_W  word read from data memory
//  mem_pc_plus4    in   DATA_W  link address
//  mem_load_type   in   3       [2] unsigned, [1:0] size: 00 B, 01 H, 1x W
//  regWrite        out  1       write enable to regFile
//  Jreg            out  1       jr flag to regFile
//  writeReg        out  REG_AW  write index to regFile
//  writeData       out  DATA_W  write data to regFile
//  wb_valid        out  1       stage holds a valid instruction
//  retire_count    out  32      retired-instruction counter
// BEHAVIOUR
//  - Reset (async, rst_n=0)
//    - Clears valid_q, all captured fields and retire_count.
//    - All outputs are 0 while reset is held and right after release.
//  - Capture on posedge clk; priority flush > stall > load
//    - flush: valid_q<=0.
//    - stall: all state held.
//    - otherwise: valid_q<=in_valid; fields <= mem_* inputs.
//  - Latency: one cycle, MEM inputs to outputs.
//  - Outputs (combinational from registered state)
//    - wb_valid = valid_q.
//    - Jreg = valid_q & jreg_q.
//    - writeReg = dest_q.
//    - regWrite = valid_q & reg_write_q & (dest_q != 0).
//    - Writes to $0 are never issued.
//    - regFile applies Jreg gating itself; regWrite is not gated by Jreg here.
//  - writeData source by wb_sel_q
//    - 00 or 11: alu_q.
//    - 01: load path.
//    - 10: pc4_q.
//  - Stall: outputs held every stalled cycle. The repeated regFile write is
//    idempotent and allowed.
//  - Retire counter
//    - Increments on an edge where valid_q=1 and (stall=0 or flush=1),
//      i.e. when a valid instruction leaves the stage.
//    - dest=$0 and Jreg instructions still count.
//    - Counts at most once per instruction; wraps 0xFFFFFFFF -> 0.
//  - flush with stall=1: flush wins. The current instruction leaves and is
//    counted; a bubble enters.
// CONFIGURATION
//  LOAD_EXT_EN defined:
//   - Load path extracts from mem_load_data, little-endian; byte n = bits 8n+7:8n.
//   - B: byte at alu_q[1:0].
//   - H: halfword at alu_q[1]; alu_q[0] is ignored.
//   - W: full word.
//   - Extension: zero-extend if load_type[2]=1, else sign-extend.
//  LOAD_EXT_EN undefined:
//   - Load path = mem_load_data unchanged.
//   - mem_load_type is captured but ignored.
// TESTING
//  1. Valid ALU write captured, then rst_n=0 mid-cycle -> regWrite, writeData,
//     wb_valid and retire_count read 0 immediately, before the next edge.
//  2. reg_write=1, dest=5, alu=0x1234, sel=00 -> next cycle regWrite=1,
//     writeReg=5, writeData=0x00001234; retire_count 0->1 on the following edge.
//  3. dest=0, reg_write=1 -> regWrite=0 throughout; retire_count still +1.
//  4. jal: sel=10, dest=31, pc4=0x00400008, reg_write=1 -> writeReg=31,
//     writeData=0x00400008; jr: jreg=1 -> Jreg=1.
//  5. stall=1 for 3 cycles with valid instruction -> outputs constant,
//     retire_count +1 only when stall drops; stall=1 & flush=1 -> wb_valid=0
//     next cycle, count +1.
//  6. LOAD_EXT_EN, load_data=0x80FF7F01, sel=01:
//     - lb  addr=2 -> 0xFFFFFFFF
//     - lbu addr=3 -> 0x00000080
//     - lh  addr=2 -> 0xFFFF80FF
//     - lhu addr=0 -> 0x00007F01
//     Without LOAD_EXT_EN, all four -> 0x80FF7F01.

Source files
------------

// File: rtl/wb_stage_if.sv
// MEM-to-WB bus plus the regFile writeback outputs of wb_stage.
// The slave modport is the stage itself; the master modport is the MEM/regFile side.
interface wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) ();
    logic              in_valid;
    logic              stall;
    logic              flush;
    logic              mem_reg_write;
    logic              mem_jreg;
    logic [1:0]        mem_wb_sel;
    logic [REG_AW-1:0] mem_dest;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] mem_load_data;
    logic [DATA_W-1:0] mem_pc_plus4;
    logic [2:0]        mem_load_type;

    logic              regWrite;
    logic              Jreg;
    logic [REG_AW-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic              wb_valid;
    logic [31:0]       retire_count;

    modport slave (
        input  in_valid, stall, flush, mem_reg_write, mem_jreg, mem_wb_sel,
               mem_dest, mem_alu_result, mem_load_data, mem_pc_plus4, mem_load_type,
        output regWrite, Jreg, writeReg, writeData, wb_valid, retire_count
    );

    modport master (
        output in_valid, stall, flush, mem_reg_write, mem_jreg, mem_wb_sel,
               mem_dest, mem_alu_result, mem_load_data, mem_pc_plus4, mem_load_type,
        input  regWrite, Jreg, writeReg, writeData, wb_valid, retire_count
    );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, writeback mux and retired-instruction counter.
// Optional macro LOAD_EXT_EN enables byte/halfword load extraction with sign/zero extension.
module wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_stage_if.slave  bus
);

    logic              valid_q,     valid_d;
    logic              reg_write_q, reg_write_d;
    logic              jreg_q,      jreg_d;
    logic [1:0]        wb_sel_q,    wb_sel_d;
    logic [REG_AW-1:0] dest_q,      dest_d;
    logic [DATA_W-1:0] alu_q,       alu_d;
    logic [DATA_W-1:0] load_q,      load_d;
    logic [DATA_W-1:0] pc4_q,       pc4_d;
    logic [2:0]        load_type_q, load_type_d;
    logic [31:0]       retire_q,    retire_d;

    logic [DATA_W-1:0] load_path;
    logic [DATA_W-1:0] write_data;

`ifdef LOAD_EXT_EN
    function automatic logic [DATA_W-1:0] load_extract(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        addr,
        input logic [2:0]        ltype
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{addr, 3'b000} +: 8];
        h = word[{addr[1], 4'b0000} +: 16];
        if (ltype[1])
            return word;
        else if (ltype[0])
            return {{(DATA_W-16){h[15] & ~ltype[2]}}, h};
        else
            return {{(DATA_W-8){b[7] & ~ltype[2]}}, b};
    endfunction

    assign load_path = load_extract(load_q, alu_q[1:0], load_type_q);
`else
    logic unused_load_type;
    assign unused_load_type = ^load_type_q;
    assign load_path        = load_q;
`endif

    // Stage register update: flush beats stall beats load; a departing valid
    // instruction (no stall, or flushed out) bumps the retire counter.
    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        jreg_d      = jreg_q;
        wb_sel_d    = wb_sel_q;
        dest_d      = dest_q;
        alu_d       = alu_q;
        load_d      = load_q;
        pc4_d       = pc4_q;
        load_type_d = load_type_q;
        retire_d    = retire_q;

        if (valid_q && (!bus.stall || bus.flush))
            retire_d = retire_q + 32'd1;

        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (!bus.stall) begin
            valid_d     = bus.in_valid;
            reg_write_d = bus.mem_reg_write;
            jreg_d      = bus.mem_jreg;
            wb_sel_d    = bus.mem_wb_sel;
            dest_d      = bus.mem_dest;
            alu_d       = bus.mem_alu_result;
            load_d      = bus.mem_load_data;
            pc4_d       = bus.mem_pc_plus4;
            load_type_d = bus.mem_load_type;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            jreg_q      <= 1'b0;
            wb_sel_q    <= 2'b00;
            dest_q      <= '0;
            alu_q       <= '0;
            load_q      <= '0;
            pc4_q       <= '0;
            load_type_q <= 3'b000;
            retire_q    <= 32'd0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            jreg_q      <= jreg_d;
            wb_sel_q    <= wb_sel_d;
            dest_q      <= dest_d;
            alu_q       <= alu_d;
            load_q      <= load_d;
            pc4_q       <= pc4_d;
            load_type_q <= load_type_d;
            retire_q    <= retire_d;
        end
    end

    always_comb begin
        write_data = alu_q;
        case (wb_sel_q)
            2'b01:   write_data = load_path;
            2'b10:   write_data = pc4_q;
            default: write_data = alu_q;
        endcase
    end

    // Writes to $0 are suppressed here; Jreg gating is left to regFile.
    assign bus.regWrite     = valid_q & reg_write_q & (dest_q != '0);
    assign bus.Jreg         = valid_q & jreg_q;
    assign bus.writeReg     = dest_q;
    assign bus.writeData    = write_data;
    assign bus.wb_valid     = valid_q;
    assign bus.retire_count = retire_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed literal checks plus randomized traffic against a behavioural model.
module tb_wb_stage;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    wb_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

    wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state: what the stage holds after each edge.
    bit          m_valid;
    bit          m_rw;
    bit          m_jr;
    logic [1:0]  m_sel;
    logic [4:0]  m_dest;
    logic [31:0] m_alu;
    logic [31:0] m_ld;
    logic [31:0] m_pc4;
    logic [2:0]  m_lt;
    logic [31:0] m_cnt;

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                               input logic [2:0] t);
`ifdef LOAD_EXT_EN
        int          bits;
        int unsigned sh;
        logic [31:0] mask;
        logic [31:0] v;
        if (t[1]) return w;
        bits = t[0] ? 16 : 8;
        sh   = t[0] ? (a & 32'd2) * 8 : (a & 32'd3) * 8;
        mask = (32'd1 << bits) - 32'd1;
        v    = (w >> sh) & mask;
        if (!t[2] && v[bits-1]) v = v | ~mask;
        return v;
`else
        return w;
`endif
    endfunction

    function automatic logic [31:0] model_data();
        if (m_sel == 2'd1) return model_load(m_ld, m_alu, m_lt);
        if (m_sel == 2'd2) return m_pc4;
        return m_alu;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0; m_rw = 0; m_jr = 0; m_sel = 0; m_dest = 0;
            m_alu = 0; m_ld = 0; m_pc4 = 0; m_lt = 0; m_cnt = 0;
        end else begin
            if (m_valid && (!bus.stall || bus.flush)) m_cnt = m_cnt + 32'd1;
            if (bus.flush) begin
                m_valid = 0;
            end else if (!bus.stall) begin
                m_valid = bus.in_valid;
                m_rw    = bus.mem_reg_write;
                m_jr    = bus.mem_jreg;
                m_sel   = bus.mem_wb_sel;
                m_dest  = bus.mem_dest;
                m_alu   = bus.mem_alu_result;
                m_ld    = bus.mem_load_data;
                m_pc4   = bus.mem_pc_plus4;
                m_lt    = bus.mem_load_type;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m_wb_valid", {31'd0, bus.wb_valid}, {31'd0, m_valid});
        chk("m_regWrite", {31'd0, bus.regWrite}, {31'd0, m_valid && m_rw && (m_dest != 0)});
        chk("m_Jreg",     {31'd0, bus.Jreg},     {31'd0, m_valid && m_jr});
        chk("m_writeReg", {27'd0, bus.writeReg}, {27'd0, m_dest});
        chk("m_writeData", bus.writeData, model_data());
        chk("m_retire",    bus.retire_count, m_cnt);
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.in_valid = 0; bus.stall = 0; bus.flush = 0; bus.mem_reg_write = 0;
        bus.mem_jreg = 0; bus.mem_wb_sel = 0; bus.mem_dest = 0; bus.mem_alu_result = 0;
        bus.mem_load_data = 0; bus.mem_pc_plus4 = 0; bus.mem_load_type = 0;
    endtask

    task automatic instr(input bit rw, input bit jr, input logic [1:0] sel, input logic [4:0] dest,
                         input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc4,
                         input logic [2:0] lt);
        bus.in_valid = 1; bus.mem_reg_write = rw; bus.mem_jreg = jr; bus.mem_wb_sel = sel;
        bus.mem_dest = dest; bus.mem_alu_result = alu; bus.mem_load_data = ld;
        bus.mem_pc_plus4 = pc4; bus.mem_load_type = lt;
    endtask

    logic [31:0] c0;
    logic [31:0] ld_addr [4];
    logic [2:0]  ld_type [4];
    logic [31:0] ld_exp  [4];

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst_n = 0;
        idle_inputs();
        @(negedge clk);
        chk("rst_wb_valid",  {31'd0, bus.wb_valid}, 32'd0);
        chk("rst_writeData", bus.writeData, 32'd0);
        chk("rst_retire",    bus.retire_count, 32'd0);
        @(negedge clk);
        rst_n = 1;

        // Mid-cycle asynchronous reset after some retired work.
        for (int i = 0; i < 3; i++) begin
            instr(1, 0, 2'd0, 5'd3, 32'h100 + i, 0, 0, 0);
            step();
        end
        chk("pre_rst_retire", bus.retire_count, 32'd2);
        chk("pre_rst_regWrite", {31'd0, bus.regWrite}, 32'd1);
        #2 rst_n = 0;
        #1;
        chk("async_regWrite",  {31'd0, bus.regWrite}, 32'd0);
        chk("async_writeData", bus.writeData, 32'd0);
        chk("async_wb_valid",  {31'd0, bus.wb_valid}, 32'd0);
        chk("async_retire",    bus.retire_count, 32'd0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        step();

        // Basic ALU writeback and retire timing.
        instr(1, 0, 2'd0, 5'd5, 32'h1234, 32'hDEAD, 32'h4, 0);
        step();
        idle_inputs();
        chk("alu_regWrite",  {31'd0, bus.regWrite}, 32'd1);
        chk("alu_writeReg",  {27'd0, bus.writeReg}, 32'd5);
        chk("alu_writeData", bus.writeData, 32'h00001234);
        chk("alu_retire0",   bus.retire_count, 32'd0);
        step();
        chk("alu_retire1",   bus.retire_count, 32'd1);

        // Destination $0 still retires.
        instr(1, 0, 2'd0, 5'd0, 32'h55, 0, 0, 0);
        step();
        idle_inputs();
        chk("r0_regWrite", {31'd0, bus.regWrite}, 32'd0);
        chk("r0_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        step();
        chk("r0_retire",   bus.retire_count, 32'd2);

        // jal link and jr flag.
        instr(1, 0, 2'd2, 5'd31, 32'h9, 0, 32'h00400008, 0);
        step();
        chk("jal_writeReg",  {27'd0, bus.writeReg}, 32'd31);
        chk("jal_writeData", bus.writeData, 32'h00400008);
        instr(0, 1, 2'd0, 5'd0, 32'h0, 0, 0, 0);
        step();
        idle_inputs();
        chk("jr_Jreg", {31'd0, bus.Jreg}, 32'd1);
        step();

        // Three stalled cycles hold outputs; count moves only on release.
        instr(1, 0, 2'd0, 5'd7, 32'hCAFE, 0, 0, 0);
        step();
        c0 = bus.retire_count;
        bus.stall = 1;
        instr(1, 0, 2'd0, 5'd9, 32'hBEEF, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_writeData", bus.writeData, 32'hCAFE);
            chk("stall_retire",    bus.retire_count, c0);
        end
        bus.stall = 0;
        idle_inputs();
        step();
        chk("unstall_retire", bus.retire_count, c0 + 32'd1);
        chk("unstall_valid",  {31'd0, bus.wb_valid}, 32'd0);

        // flush together with stall: instruction leaves and counts.
        instr(1, 0, 2'd0, 5'd4, 32'h77, 0, 0, 0);
        step();
        c0 = bus.retire_count;
        bus.stall = 1;
        bus.flush = 1;
        step();
        idle_inputs();
        chk("flush_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("flush_retire",   bus.retire_count, c0 + 32'd1);

        // Load path on a fixed word.
        ld_addr[0] = 32'd2; ld_type[0] = 3'b000;
        ld_addr[1] = 32'd3; ld_type[1] = 3'b100;
        ld_addr[2] = 32'd2; ld_type[2] = 3'b001;
        ld_addr[3] = 32'd0; ld_type[3] = 3'b101;
`ifdef LOAD_EXT_EN
        ld_exp[0] = 32'hFFFFFFFF; ld_exp[1] = 32'h00000080;
        ld_exp[2] = 32'hFFFF80FF; ld_exp[3] = 32'h00007F01;
`else
        ld_exp[0] = 32'h80FF7F01; ld_exp[1] = 32'h80FF7F01;
        ld_exp[2] = 32'h80FF7F01; ld_exp[3] = 32'h80FF7F01;
`endif
        for (int i = 0; i < 4; i++) begin
            instr(1, 0, 2'd1, 5'd8, ld_addr[i], 32'h80FF7F01, 0, ld_type[i]);
            step();
            chk("load_writeData", bus.writeData, ld_exp[i]);
        end
        idle_inputs();
        step();

        // Randomized traffic; the negedge compare process does the checking.
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid       = ($urandom_range(0, 3) != 0);
            bus.stall          = ($urandom_range(0, 3) == 0);
            bus.flush          = ($urandom_range(0, 9) == 0);
            bus.mem_reg_write  = $urandom_range(0, 1);
            bus.mem_jreg       = ($urandom_range(0, 7) == 0);
            bus.mem_wb_sel     = 2'($urandom_range(0, 3));
            bus.mem_dest       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            bus.mem_alu_result = $urandom;
            bus.mem_load_data  = $urandom;
            bus.mem_pc_plus4   = $urandom;
            bus.mem_load_type  = 3'($urandom);
            if (i == 1500) begin
                #2 rst_n = 0;
                #1 rst_n = 1;
            end
            step();
        end

        idle_inputs();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
